alu_issue_ctrl: RTL and testbench

Execute-stage front end that issues operand/opcode requests into the combinational 16-bit ALU and returns registered results. It accepts requests on a valid/ready channel and holds them in an operand stage (S1) that drives the ALU ports. It captures the ALU answer plus status flags in a result stage (S2) and presents them on a valid/ready response channel. Sits between decode/register-read and writeback; it is the producer/consumer end of the ALU's A/B/op/ans interface.

---
 rtl/alu_issue_ctrl_if.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 103 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channel bundle between the issue logic (master) and alu_issue_ctrl (slave).
interface alu_issue_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int TAG_W  = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic [OP_W-1:0]   req_op;
   logic [TAG_W-1:0]  req_tag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_ans;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_zero;
   logic              rsp_neg;
   logic              rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_ans, rsp_tag, rsp_zero, rsp_neg, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_ans, rsp_tag, rsp_zero, rsp_neg, rsp_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-stage ALU issue front end: operand stage S1 drives the ALU, result stage S2 holds the response.
// Optional macro ALU_OPCHK_EN: opcodes >= 8 are illegal and return err=1 with a zero result.
module alu_issue_ctrl #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   alu_issue_ctrl_if.slave   bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_ans,
   output logic              busy,
   output logic [15:0]       op_count
);
   logic              live;
   logic              s1_valid;
   logic [TAG_W-1:0]  s1_tag;
   logic              s2_free;
   logic              s1_adv;
   logic              accept;
   logic              rsp_fire;
   logic              nxt_err;
   logic [DATA_W-1:0] nxt_ans;

   assign s2_free       = !bus.rsp_valid || bus.rsp_ready;
   assign s1_adv        = s1_valid && s2_free;
   assign bus.req_ready = live && !flush && (!s1_valid || s1_adv);
   assign accept        = bus.req_valid && bus.req_ready;
   assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
   assign busy          = s1_valid || bus.rsp_valid;

`ifdef ALU_OPCHK_EN
   assign nxt_err = (alu_op >= OP_W'(8));
`else
   assign nxt_err     = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif
   assign nxt_ans = nxt_err ? '0 : alu_ans;

   // live keeps req_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live     <= 1'b0;
         s1_valid <= 1'b0;
         s1_tag   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
      end else begin
         live <= 1'b1;
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (accept) begin
            s1_valid <= 1'b1;
            s1_tag   <= bus.req_tag;
            alu_a    <= bus.req_a;
            alu_b    <= bus.req_b;
            alu_op   <= bus.req_op;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Result stage captures the ALU answer as S1 advances; flush only drops the valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_ans   <= '0;
         bus.rsp_tag   <= '0;
         bus.rsp_zero  <= 1'b0;
         bus.rsp_neg   <= 1'b0;
`ifdef ALU_OPCHK_EN
         bus.rsp_err   <= 1'b0;
`endif
      end else if (flush) begin
         bus.rsp_valid <= 1'b0;
      end else if (s1_adv) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_ans   <= nxt_ans;
         bus.rsp_tag   <= s1_tag;
         bus.rsp_zero  <= (nxt_ans == '0);
         bus.rsp_neg   <= nxt_ans[DATA_W-1];
`ifdef ALU_OPCHK_EN
         bus.rsp_err   <= nxt_err;
`endif
      end else if (rsp_fire) begin
         bus.rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (rsp_fire) begin
         op_count <= op_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a capacity-2 in-order queue model checked every cycle,
// plus directed vectors with literal expectations. ALU stub computes ans = A + B.
module tb_alu_issue_ctrl;
   localparam int DW = 16;
   localparam int OW = 4;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_ans;
   logic [OW-1:0] alu_op;
   logic          busy;
   logic [15:0]   op_count;

   int checks = 0;
   int errors = 0;

   alu_issue_ctrl_if #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) bus();

   alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .bus      (bus),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_ans  (alu_ans),
      .busy     (busy),
      .op_count (op_count)
   );

   assign alu_ans = alu_a + alu_b;

   always #5 clk = ~clk;

   // Model: in-flight requests in order; an entry becomes visible once it has sat through an edge at the head
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [3:0]  tag;
      bit          vis;
   } ent_t;

   ent_t        q[$];
   ent_t        e;
   ent_t        s1e;
   logic [15:0] mcount = 16'd0;
   bit          mlive = 1'b0;
   bit          exp_rdy;
   bit          exp_rv;
   bit          s1_occ;

   function automatic logic expErr(input ent_t x);
`ifdef ALU_OPCHK_EN
      return (x.op >= 4'd8);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] expAns(input ent_t x);
      if (expErr(x)) return 16'h0000;
      return x.a + x.b;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] op, input logic [3:0] tag,
                                input logic rr, input logic fl);
      bus.req_valid = v;
      bus.req_a     = v ? a : 16'hxxxx;
      bus.req_b     = v ? b : 16'hxxxx;
      bus.req_op    = v ? op : 4'hx;
      bus.req_tag   = v ? tag : 4'hx;
      bus.rsp_ready = rr;
      flush         = fl;
      @(posedge clk);
      #2;
   endtask

   // Compare process: mid-cycle, check outputs against the model, then apply the coming edge to it
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         mcount = 16'd0;
         mlive  = 1'b0;
         checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
         checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
         checkOutput("rst_busy", {31'd0, busy}, 32'd0);
         checkOutput("rst_op_count", {16'd0, op_count}, 32'd0);
         checkOutput("rst_rsp_ans", {16'd0, bus.rsp_ans}, 32'd0);
         checkOutput("rst_alu_a", {16'd0, alu_a}, 32'd0);
      end else begin
         exp_rdy = mlive && !flush && (q.size() < 2 || bus.rsp_ready);
         exp_rv  = (q.size() > 0) && q[0].vis;
         checkOutput("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_rdy});
         checkOutput("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_rv});
         checkOutput("busy", {31'd0, busy}, {31'd0, q.size() > 0});
         checkOutput("op_count", {16'd0, op_count}, {16'd0, mcount});
         if (exp_rv) begin
            checkOutput("rsp_ans", {16'd0, bus.rsp_ans}, {16'd0, expAns(q[0])});
            checkOutput("rsp_tag", {28'd0, bus.rsp_tag}, {28'd0, q[0].tag});
            checkOutput("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, expAns(q[0]) == 16'h0});
            checkOutput("rsp_neg", {31'd0, bus.rsp_neg}, {31'd0, expAns(q[0]) >= 16'h8000});
            checkOutput("rsp_err", {31'd0, bus.rsp_err}, {31'd0, expErr(q[0])});
         end
         s1_occ = 1'b0;
         if (q.size() == 2) begin
            s1e = q[1];
            s1_occ = 1'b1;
         end else if (q.size() == 1 && !q[0].vis) begin
            s1e = q[0];
            s1_occ = 1'b1;
         end
         if (s1_occ) begin
            checkOutput("alu_a", {16'd0, alu_a}, {16'd0, s1e.a});
            checkOutput("alu_b", {16'd0, alu_b}, {16'd0, s1e.b});
            checkOutput("alu_op", {28'd0, alu_op}, {28'd0, s1e.op});
         end
         if (exp_rv && bus.rsp_ready) begin
            void'(q.pop_front());
            mcount = mcount + 16'd1;
         end
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() > 0) begin
               e = q[0];
               e.vis = 1'b1;
               q[0] = e;
            end
            if (bus.req_valid && exp_rdy) begin
               e.a   = bus.req_a;
               e.b   = bus.req_b;
               e.op  = bus.req_op;
               e.tag = bus.req_tag;
               e.vis = 1'b0;
               q.push_back(e);
            end
         end
         mlive = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_a     = 16'h0;
      bus.req_b     = 16'h0;
      bus.req_op    = 4'h0;
      bus.req_tag   = 4'h0;
      bus.rsp_ready = 1'b0;
      #3;
      checkOutput("init_req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("init_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);

      // Single request: response visible one edge after S1 load
      applyStimulus(1'b1, 16'h8010, 16'h0008, 4'h0, 4'd3, 1'b1, 1'b0);
      checkOutput("t1_s1_only", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("t1_alu_a", {16'd0, alu_a}, 32'h8010);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("t1_rsp_ans", {16'd0, bus.rsp_ans}, 32'h8018);
      checkOutput("t1_rsp_tag", {28'd0, bus.rsp_tag}, 32'd3);
      checkOutput("t1_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
      checkOutput("t1_rsp_neg", {31'd0, bus.rsp_neg}, 32'd1);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t1_op_count", {16'd0, op_count}, 32'd1);

      // Back-to-back stream
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 16'(i), 16'h0010, 4'h0, 4'(i), 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t2_op_count", {16'd0, op_count}, 32'd9);

      // Backpressure: three requests offered over five stalled cycles
      applyStimulus(1'b1, 16'h0100, 16'h0001, 4'h0, 4'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0200, 16'h0001, 4'h0, 4'd6, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 16'h0300, 16'h0001, 4'h0, 4'd7, 1'b0, 1'b0);
      checkOutput("t3_hold_ans", {16'd0, bus.rsp_ans}, 32'h0101);
      checkOutput("t3_hold_tag", {28'd0, bus.rsp_tag}, 32'd5);
      checkOutput("t3_hold_alu_a", {16'd0, alu_a}, 32'h0200);
      checkOutput("t3_op_count", {16'd0, op_count}, 32'd9);
      applyStimulus(1'b1, 16'h0300, 16'h0001, 4'h0, 4'd7, 1'b1, 1'b0);
      checkOutput("t3_second_ans", {16'd0, bus.rsp_ans}, 32'h0201);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t3_third_ans", {16'd0, bus.rsp_ans}, 32'h0301);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t3_op_count_end", {16'd0, op_count}, 32'd12);

      // Wraparound to zero
      applyStimulus(1'b1, 16'hFFFF, 16'h0001, 4'h0, 4'd9, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t4_rsp_ans", {16'd0, bus.rsp_ans}, 32'h0000);
      checkOutput("t4_rsp_zero", {31'd0, bus.rsp_zero}, 32'd1);
      checkOutput("t4_rsp_neg", {31'd0, bus.rsp_neg}, 32'd0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);

      // Flush with both stages full and a request offered
      applyStimulus(1'b1, 16'h0001, 16'h0001, 4'h0, 4'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0002, 16'h0002, 4'h0, 4'd2, 1'b0, 1'b0);
      checkOutput("t5_full_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b1, 16'h0AAA, 16'h0001, 4'h0, 4'd4, 1'b0, 1'b1);
      checkOutput("t5_flush_rv", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("t5_flush_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_flush_cnt", {16'd0, op_count}, 32'd13);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t5_no_accept", {31'd0, busy}, 32'd0);

      // Handshake in the flush cycle still counts
      applyStimulus(1'b1, 16'h0003, 16'h0003, 4'h0, 4'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b1);
      checkOutput("t5b_cnt", {16'd0, op_count}, 32'd14);

      // Asynchronous reset mid-stream
      applyStimulus(1'b1, 16'h0005, 16'h0005, 4'h0, 4'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0006, 16'h0006, 4'h0, 4'd2, 1'b0, 1'b0);
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      checkOutput("t6_rv", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("t6_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_cnt", {16'd0, op_count}, 32'd0);
      checkOutput("t6_ans", {16'd0, bus.rsp_ans}, 32'd0);
      checkOutput("t6_alu_a", {16'd0, alu_a}, 32'd0);
      checkOutput("t6_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h00AA, 16'h0055, 4'h0, 4'd2, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t6_post_ans", {16'd0, bus.rsp_ans}, 32'h00FF);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);

      // Opcode 9
      applyStimulus(1'b1, 16'h1234, 16'h0001, 4'h9, 4'd4, 1'b1, 1'b0);
      checkOutput("t7_alu_op", {28'd0, alu_op}, 32'h9);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
`ifdef ALU_OPCHK_EN
      checkOutput("t7_err", {31'd0, bus.rsp_err}, 32'd1);
      checkOutput("t7_ans", {16'd0, bus.rsp_ans}, 32'h0000);
      checkOutput("t7_zero", {31'd0, bus.rsp_zero}, 32'd1);
`else
      checkOutput("t7_err", {31'd0, bus.rsp_err}, 32'd0);
      checkOutput("t7_ans", {16'd0, bus.rsp_ans}, 32'h1235);
      checkOutput("t7_zero", {31'd0, bus.rsp_zero}, 32'd0);
`endif
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("t7_cnt", {16'd0, op_count}, 32'd2);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
